// File: rtl/conv1d_pkg.sv
// Shared definitions for the CONV1D 3rd-layer RAM controller: FSM states and size limits.
// Latency: none (types and constants only).
// Backpressure: n/a.
package conv1d_pkg;

  // Largest job the controller can address: channels x positions per channel.
  localparam int MAX_DEPTH = 16;
  localparam int MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READ,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/conv1d_addr_cnt.sv
// Two-level nested address counter: inner index runs 0..inner_last, then outer steps.
// Latency: new address one cycle after advance; last is combinational on the current address.
// Backpressure: moves only when advance=1, otherwise holds.
// Ports: clk/reset (sync, active-high); clear returns to (0,0); advance steps once;
//        inner_last/outer_last are the final indices; inner/outer are the current address;
//        last flags the final address (inner_last, outer_last).
module conv1d_addr_cnt
  import conv1d_pkg::*;
#(
  parameter int IW = 8,
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [IW-1:0] inner_last,
  input  logic [OW-1:0] outer_last,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);

  logic inner_wrap;

  assign inner_wrap = (inner == inner_last);
  assign last       = inner_wrap && (outer == outer_last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      inner <= '0;
      outer <= '0;
    end else if (advance) begin
      if (inner_wrap) begin
        inner <= '0;
        // Wrapping from the final address back to (0,0) leaves the counter
        // ready for the next job without relying on the clear.
        outer <= last ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv1d_3rd_ram_ctrl.sv
// Fill/read sequencer for the external CONV1D 3rd-layer data RAM (holds no storage itself).
// Latency: RAM write same cycle as accepted word; win_valid one cycle after Read_Enable.
// Backpressure: in_ready only in FILL; reads stall on out_ready=0, windows are not stallable.
// Ports: CLK/Reset (sync, active-high); start + cfg_depth_num/cfg_width_num launch a job;
//        in_valid/in_data/in_ready input stream; out_ready consumer throttle;
//        Write_*/data_in and Read_* RAM ports; win_valid/win_last window strobe; busy/done status.
module conv1d_3rd_ram_ctrl
  import conv1d_pkg::*;
#(
  parameter int Bit_width = 16,
  parameter int Max_Depth = MAX_DEPTH,
  parameter int Max_Width = MAX_WIDTH,
  localparam int DW = $clog2(Max_Depth),
  localparam int WW = $clog2(Max_Width)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [DW:0]          cfg_depth_num,
  input  logic [WW:0]          cfg_width_num,
  input  logic                 in_valid,
  input  logic [Bit_width-1:0] in_data,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 Write_Enable,
  output logic [DW-1:0]        Write_Depth,
  output logic [WW-1:0]        Write_Width,
  output logic [Bit_width-1:0] data_in,
  output logic                 Read_Enable,
  output logic [DW-1:0]        Read_Depth,
  output logic [WW-1:0]        Read_Width,
  output logic                 win_valid,
  output logic                 win_last,
  output logic                 busy,
  output logic                 done
);

  state_t        state;
  logic [DW-1:0] d_last;
  logic [WW-1:0] w_last;
  logic [DW:0]   dep_num;
  logic [WW:0]   wid_num;
  logic          job_start;

  logic [DW-1:0] wr_d_cnt, rd_d_cnt, wr_d_q, rd_d_q;
  logic [WW-1:0] wr_w_cnt, rd_w_cnt, wr_w_q, rd_w_q;
  logic          wr_last, rd_last;

  // Out-of-range configuration is clamped into 1..max.
  always_comb begin
    dep_num = cfg_depth_num;
    if (cfg_depth_num == '0)
      dep_num = (DW+1)'(1);
    else if (cfg_depth_num > (DW+1)'(Max_Depth))
      dep_num = (DW+1)'(Max_Depth);

    wid_num = cfg_width_num;
    if (cfg_width_num == '0)
      wid_num = (WW+1)'(1);
    else if (cfg_width_num > (WW+1)'(Max_Width))
      wid_num = (WW+1)'(Max_Width);
  end

  assign job_start    = (state == S_IDLE) && start;
  assign Write_Enable = in_valid && in_ready;
  assign Read_Enable  = out_ready && (state == S_READ);
  assign data_in      = in_data;

  // Write order: width inner, depth outer.
  conv1d_addr_cnt #(.IW(WW), .OW(DW)) u_wr_cnt (
    .clk        (CLK),
    .reset      (Reset),
    .clear      (job_start),
    .advance    (Write_Enable),
    .inner_last (w_last),
    .outer_last (d_last),
    .inner      (wr_w_cnt),
    .outer      (wr_d_cnt),
    .last       (wr_last)
  );

  // Read order: depth inner, width outer (all channels of one position together).
  conv1d_addr_cnt #(.IW(DW), .OW(WW)) u_rd_cnt (
    .clk        (CLK),
    .reset      (Reset),
    .clear      (job_start),
    .advance    (Read_Enable),
    .inner_last (d_last),
    .outer_last (w_last),
    .inner      (rd_d_cnt),
    .outer      (rd_w_cnt),
    .last       (rd_last)
  );

  // Addresses show the live counter while enabled and the last used address otherwise,
  // so the wrap back to (0,0) after the final access is never visible on the RAM port.
  assign Write_Depth = Write_Enable ? wr_d_cnt : wr_d_q;
  assign Write_Width = Write_Enable ? wr_w_cnt : wr_w_q;
  assign Read_Depth  = Read_Enable  ? rd_d_cnt : rd_d_q;
  assign Read_Width  = Read_Enable  ? rd_w_cnt : rd_w_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      d_last   <= '0;
      w_last   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            d_last   <= DW'(dep_num - 1'b1);
            w_last   <= WW'(wid_num - 1'b1);
            state    <= S_FILL;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FILL: begin
          if (Write_Enable && wr_last) begin
            state    <= S_READ;
            in_ready <= 1'b0;
          end
        end
        S_READ: begin
          if (Read_Enable && rd_last)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The final window is on the bus this cycle; done follows it.
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_d_q    <= '0;
      wr_w_q    <= '0;
      rd_d_q    <= '0;
      rd_w_q    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      // Fixed one-cycle RAM read latency.
      win_valid <= Read_Enable;
      win_last  <= Read_Enable && rd_last;
      if (Write_Enable) begin
        wr_d_q <= wr_d_cnt;
        wr_w_q <= wr_w_cnt;
      end
      if (Read_Enable) begin
        rd_d_q <= rd_d_cnt;
        rd_w_q <= rd_w_cnt;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_3rd_ram_ctrl.sv
`timescale 1ns/1ps
module tb_conv1d_3rd_ram_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_depth_num = '0;
  logic [8:0]  cfg_width_num = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_ready = 1'b0;
  logic        Write_Enable;
  logic [3:0]  Write_Depth;
  logic [7:0]  Write_Width;
  logic [15:0] data_in;
  logic        Read_Enable;
  logic [3:0]  Read_Depth;
  logic [7:0]  Read_Width;
  logic        win_valid, win_last, busy, done;

  conv1d_3rd_ram_ctrl #(.Bit_width(16), .Max_Depth(16), .Max_Width(256)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .start         (start),
    .cfg_depth_num (cfg_depth_num),
    .cfg_width_num (cfg_width_num),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .Write_Enable  (Write_Enable),
    .Write_Depth   (Write_Depth),
    .Write_Width   (Write_Width),
    .data_in       (data_in),
    .Read_Enable   (Read_Enable),
    .Read_Depth    (Read_Depth),
    .Read_Width    (Read_Width),
    .win_valid     (win_valid),
    .win_last      (win_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 CLK = ~CLK;

  typedef struct { int d; int w; int dat; } wexp_t;
  typedef struct { int d; int w; bit last; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t mwe;
  rexp_t mre;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int win_cnt = 0;
  bit pend_vld = 1'b0;
  bit pend_last = 1'b0;
  bit pend_done = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] wdata(input int k);
    return 16'(k * 37 + 90);
  endfunction

  // Monitor: pops expectations whenever the DUT drives a RAM access, window or done.
  always @(negedge CLK) begin
    if (Write_Enable || Read_Enable)
      chk("en_overlap", 32'(Write_Enable & Read_Enable), 0);

    if (Write_Enable === 1'b1) begin
      if (wq.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL wr_extra: write at d=%0d w=%0d, expected no write", Write_Depth, Write_Width);
      end else begin
        mwe = wq.pop_front();
        chk("wr_depth", 32'(Write_Depth), mwe.d);
        chk("wr_width", 32'(Write_Width), mwe.w);
        chk("wr_data", 32'(data_in), mwe.dat);
      end
    end

    if (win_valid || pend_vld) begin
      chk("win_valid", 32'(win_valid), 32'(pend_vld));
      if (win_valid && pend_vld)
        chk("win_last", 32'(win_last), 32'(pend_last));
    end
    if (win_last && !win_valid)
      chk("win_last_idle", 32'(win_last), 0);
    if (win_valid) win_cnt++;

    if (done || pend_done)
      chk("done_pulse", 32'(done), 32'(pend_done));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    pend_done = win_valid && win_last && !Reset;

    pend_vld  = 1'b0;
    pend_last = 1'b0;
    if (Read_Enable === 1'b1) begin
      if (rq.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL rd_extra: read at d=%0d w=%0d, expected no read", Read_Depth, Read_Width);
      end else begin
        mre = rq.pop_front();
        chk("rd_depth", 32'(Read_Depth), mre.d);
        chk("rd_width", 32'(Read_Width), mre.w);
        pend_vld  = !Reset;
        pend_last = mre.last;
      end
    end
  end

  // One job: cfg as driven, (d, w) the effective sizes the bench expects.
  task automatic run_job(input int dep_in, input int wid_in, input int d, input int w,
                         input int iv_pct, input int or_pct, input bit spur,
                         input int rst_after, input int exp_lat, input int budget);
    int acc, base_done, base_win, n, k, st_cyc;
    bit spur_done, rst_hit;
    wq.delete();
    rq.delete();
    k = 0;
    for (int dd = 0; dd < d; dd++)
      for (int ww = 0; ww < w; ww++) begin
        wq.push_back('{dd, ww, int'(wdata(k))});
        k++;
      end
    for (int ww = 0; ww < w; ww++)
      for (int dd = 0; dd < d; dd++)
        rq.push_back('{dd, ww, (dd == d - 1) && (ww == w - 1)});

    acc = 0; n = 0; spur_done = 1'b0; rst_hit = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    cfg_depth_num = 5'(dep_in);
    cfg_width_num = 9'(wid_in);
    in_valid = 1'b0;
    out_ready = 1'b0;
    base_done = done_cnt;
    base_win = win_cnt;
    st_cyc = cyc;

    while (done_cnt == base_done && n < budget && !rst_hit) begin
      @(posedge CLK); #1;
      start = 1'b0;
      in_valid = ($urandom_range(99) < iv_pct);
      in_data = wdata(acc);
      out_ready = ($urandom_range(99) < or_pct);
      if (spur && !spur_done && acc == 2) begin
        start = 1'b1;
        cfg_depth_num = 5'd7;
        cfg_width_num = 9'd9;
        spur_done = 1'b1;
      end
      @(negedge CLK);
      if (in_valid && in_ready) acc++;
      n++;
      if (rst_after > 0 && (win_cnt - base_win) >= rst_after) rst_hit = 1'b1;
    end

    if (rst_hit) begin
      @(posedge CLK); #1;
      Reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      start = 1'b0;
      @(posedge CLK); #1;
      Reset = 1'b0;
      @(negedge CLK);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_en", 32'(Read_Enable), 0);
      chk("rst_win_valid", 32'(win_valid), 0);
      chk("rst_done", 32'(done), 0);
      out_ready = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_no_done", done_cnt - base_done, 0);
      wq.delete();
      rq.delete();
      return;
    end

    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("done_count", done_cnt - base_done, 1);
    chk("wr_accepted", acc, d * w);
    chk("win_count", win_cnt - base_win, d * w);
    chk("wr_left", wq.size(), 0);
    chk("rd_left", rq.size(), 0);
    chk("busy_end", 32'(busy), 0);
    if (exp_lat > 0)
      chk("done_latency", done_cyc - st_cyc, exp_lat);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(Write_Enable), 0);
    chk("rst_re", 32'(Read_Enable), 0);
    chk("rst_wd", 32'(Write_Depth), 0);
    chk("rst_ww", 32'(Write_Width), 0);
    chk("rst_rd", 32'(Read_Depth), 0);
    chk("rst_rw", 32'(Read_Width), 0);
    chk("rst_winv", 32'(win_valid), 0);
    chk("rst_winl", 32'(win_last), 0);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_done0", 32'(done), 0);

    // D=2, W=3, full throughput: done 14 cycles after the start cycle.
    run_job(2, 3, 2, 3, 100, 100, 1'b0, 0, 14, 200);
    @(negedge CLK);
    chk("hold_wr_depth", 32'(Write_Depth), 1);
    chk("hold_wr_width", 32'(Write_Width), 2);
    chk("hold_rd_depth", 32'(Read_Depth), 1);
    chk("hold_rd_width", 32'(Read_Width), 2);

    // Single-word job: one write, one read, done 4 cycles after start.
    run_job(1, 1, 1, 1, 100, 100, 1'b0, 0, 4, 50);

    // Full-size job with random throttling on both sides.
    run_job(16, 256, 16, 256, 50, 50, 1'b0, 0, 0, 40000);

    // Reset mid-READ after 10 windows, then a fresh job.
    run_job(4, 8, 4, 8, 100, 100, 1'b0, 10, 0, 500);
    run_job(3, 5, 3, 5, 70, 60, 1'b0, 0, 0, 500);

    // Start pulsed during FILL with other cfg must be ignored.
    run_job(3, 4, 3, 4, 100, 100, 1'b1, 0, 0, 500);

    // Clamped configuration: depth 0 -> 1, width 300 -> 256.
    run_job(0, 300, 1, 256, 100, 50, 1'b0, 0, 0, 3000);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv1d_3rd_ram_ctrl.md
CONV1D_3RD_RAM_CTRL -- requirements
Module: conv1d_3rd_ram_ctrl

Interface
REQ-001 SHALL have parameter Bit_width, default 16, data word width.
REQ-002 SHALL have parameter Max_Depth, default 16, maximum channel count.
REQ-003 SHALL have parameter Max_Width, default 256, maximum positions per channel.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high; ports: CLK  in  1  clock; Reset  in  1  sync active-high reset.
REQ-005 start  in  1  one-cycle pulse, begins a fill+read job.
REQ-006 cfg_depth_num  in  5  channel count, 1..16, sampled on accepted start.
REQ-007 cfg_width_num  in  9  positions per channel, 1..256, sampled on accepted start.
REQ-008 in_valid  in  1  input word valid; in_data  in  Bit_width  input word; in_ready  out  1  controller accepts word.
REQ-009 out_ready  in  1  consumer can take a window this cycle.
REQ-010 Write_Enable  out  1; Write_Depth  out  4; Write_Width  out  8  RAM write port.
REQ-011 data_in  out  Bit_width  RAM write data (in_data passed through).
REQ-012 Read_Enable  out  1; Read_Depth  out  4; Read_Width  out  8  RAM read port.
REQ-013 win_valid  out  1  RAM data_out_0..2 valid this cycle; win_last  out  1  final window of job.
REQ-014 busy  out  1  job in progress; done  out  1  one-cycle pulse at job end.

Function
REQ-015 FSM states SHALL be IDLE, FILL, READ, DRAIN; encoding free.
REQ-016 IDLE: start=1 SHALL latch cfg fields and go to FILL next cycle; start in any other state SHALL be ignored.
REQ-017 Out-of-range cfg (0, depth>16, width>256) SHALL be clamped: 0->1, over-max->max.
REQ-018 FILL: in_ready=1; each in_valid&in_ready cycle SHALL assert Write_Enable combinationally with current (Write_Depth, Write_Width).
REQ-019 Write order SHALL be width inner (0..W-1), depth outer (0..D-1); counters advance only on accepted word.
REQ-020 Accepting word (D-1, W-1) SHALL move FILL->READ next cycle; in_ready=0 outside FILL.
REQ-021 READ: Read_Enable SHALL equal out_ready; read address advances only when Read_Enable=1.
REQ-022 Read order SHALL be depth inner (0..D-1), width outer (0..W-1), i.e. all channels per position.
REQ-023 win_valid SHALL be Read_Enable delayed one cycle (fixed 1-cycle RAM read latency); win_valid is not stallable, consumer must accept.
REQ-024 win_last SHALL assert with win_valid for address (D-1, W-1) only.
REQ-025 Issuing read (D-1, W-1) SHALL move READ->DRAIN; DRAIN SHALL last one cycle, pulse done, return to IDLE.
REQ-026 Write_Enable and Read_Enable SHALL never be high in the same cycle.
REQ-027 busy SHALL be 1 in FILL, READ, DRAIN; 0 in IDLE.
REQ-028 Counters SHALL be sized for Max values; no wrap beyond cfg limits; D=1 and W=1 SHALL each work (single-word job = one write, one read).
REQ-029 Address outputs SHALL hold last value when their enable is low.

Reset
REQ-030 Reset=1 at any state, including mid-FILL or mid-READ, SHALL force IDLE next edge, abandon the job without done.
REQ-031 Reset values: all enables, addresses, in_ready, win_valid, win_last, busy, done = 0; latched cfg = 1/1.

Structure
REQ-032 FSM state typedef and Max_Depth/Max_Width defaults SHALL live in a shared conv1d_pkg package.
REQ-033 A single sub-module, conv1d_addr_cnt (two-level nested counter with inner/outer limits, advance, wrap/last flags), SHALL be instantiated twice (write order, read order).
REQ-034 The controller SHALL contain no RAM; it drives an external CONV1D 3rd-layer data RAM.

Verification
REQ-035 D=2, W=3, in_valid always 1, out_ready always 1 -> writes (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); reads (d,w) (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); done 8 cycles after READ entry at most, win_last on 6th window.
REQ-036 D=1, W=1 -> exactly one Write_Enable, one Read_Enable, win_valid+win_last same cycle, done next cycle.
REQ-037 D=16, W=256, in_valid random 50%, out_ready random 50% -> 4096 writes, 4096 windows in order, no enable overlap, no lost/duplicated address.
REQ-038 Reset asserted mid-READ after 10 windows -> next cycle busy=0, Read_Enable=0, win_valid=0, no done; new start runs full job correctly.
REQ-039 start pulsed during FILL with different cfg -> ignored; job completes with original D, W.
REQ-040 cfg_depth_num=0, cfg_width_num=300 -> job runs with D=1, W=256 (256 writes, 256 windows).
